mips_mc_ctrl_ws: RTL and testbench

Multi-cycle MIPS control unit: next generation of the current controller. Drives the existing multi-cycle datapath control signals (pc_write, branch, iRwrite, regWrite, IorD, regDst, memToReg, aluSrc_a/b, pc_src, alu_cntrl, memWrite).
- Adds memory wait-state handshake with timeout.
- Adds bne, addi and j.
- Illegal opcodes/functs trap to a sticky fault state.
- Optional performance counters.

---
 rtl/mips_mc_ctrl_ws.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl_ws.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_ctrl_ws
// Purpose  : Multi-cycle MIPS control unit with memory wait-state handshake
//            and timeout, R-type/lw/sw/beq/bne/addi/j support, sticky fault
//            trap on illegal opcode/funct or memory timeout.
// Revision : 1.0 - initial release
// Options  : MIPS_PERF_CNT_EN - when defined, instr_cnt/cycle_cnt are live
//            counters; otherwise both outputs are tied to zero.
// Ports    : clk, rst (sync, active-low)
//            opcode[5:0], funct[5:0]  - instruction fields from the IR
//            mem_ready                - memory completes access this cycle
//            mem_req, memWrite        - memory handshake / write strobe
//            pc_write, branch, branch_ne, iRwrite, regWrite, IorD, regDst,
//            memToReg, aluSrc_a, aluSrc_b[1:0], pc_src[1:0], alu_cntrl[2:0]
//                                     - datapath controls
//            fault                    - sticky trap flag
//            state_o[3:0]             - current state (debug)
//            instr_cnt, cycle_cnt     - performance counters
// ============================================================================
module mips_mc_ctrl_ws #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 memWrite,
    output logic                 pc_write,
    output logic                 branch,
    output logic                 branch_ne,
    output logic                 iRwrite,
    output logic                 regWrite,
    output logic                 IorD,
    output logic                 regDst,
    output logic                 memToReg,
    output logic                 aluSrc_a,
    output logic [1:0]           aluSrc_b,
    output logic [1:0]           pc_src,
    output logic [2:0]           alu_cntrl,
    output logic                 fault,
    output logic [3:0]           state_o,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_FAULT    = 4'd12
    } state_t;

    localparam logic [5:0] c_op_r    = 6'b000000;
    localparam logic [5:0] c_op_lw   = 6'b100011;
    localparam logic [5:0] c_op_sw   = 6'b101011;
    localparam logic [5:0] c_op_beq  = 6'b000100;
    localparam logic [5:0] c_op_bne  = 6'b000101;
    localparam logic [5:0] c_op_addi = 6'b001000;
    localparam logic [5:0] c_op_j    = 6'b000010;

    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int              WAIT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                funct_ok;
    logic [2:0]          funct_alu;
    logic                timeout;

    // R-type funct decode
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = c_alu_add;
        case (funct)
            6'b100000: funct_alu = c_alu_add;
            6'b100010: funct_alu = c_alu_sub;
            6'b100100: funct_alu = c_alu_and;
            6'b100101: funct_alu = c_alu_or;
            6'b101010: funct_alu = c_alu_slt;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Last allowed not-ready cycle; a simultaneous mem_ready takes priority.
    assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt_q == c_wait_last) && !mem_ready;

    // Next state and Moore/handshake outputs
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        memWrite  = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        iRwrite   = 1'b0;
        regWrite  = 1'b0;
        IorD      = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        aluSrc_a  = 1'b0;
        aluSrc_b  = 2'b00;
        pc_src    = 2'b00;
        alu_cntrl = 3'b000;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                aluSrc_b  = 2'b01;
                alu_cntrl = c_alu_add;
                pc_write  = mem_ready;
                iRwrite   = mem_ready;
                if (mem_ready)    state_d = ST_DECODE;
                else if (timeout) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                aluSrc_b  = 2'b11;
                alu_cntrl = c_alu_add;
                case (opcode)
                    c_op_lw, c_op_sw:   state_d = ST_MEMADR;
                    c_op_r:             state_d = funct_ok ? ST_EXECUTE : ST_FAULT;
                    c_op_beq, c_op_bne: state_d = ST_BRANCH;
                    c_op_addi:          state_d = ST_ADDIEXEC;
                    c_op_j:             state_d = ST_JUMP;
                    default:            state_d = ST_FAULT;
                endcase
            end
            ST_MEMADR: begin
                aluSrc_a  = 1'b1;
                aluSrc_b  = 2'b10;
                alu_cntrl = c_alu_add;
                state_d   = (opcode == c_op_sw) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)    state_d = ST_MEMWB;
                else if (timeout) state_d = ST_FAULT;
            end
            ST_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                memWrite = 1'b1;
                if (mem_ready)    state_d = ST_FETCH;
                else if (timeout) state_d = ST_FAULT;
            end
            ST_EXECUTE: begin
                aluSrc_a  = 1'b1;
                alu_cntrl = funct_alu;
                state_d   = ST_ALUWB;
            end
            ST_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BRANCH: begin
                aluSrc_a  = 1'b1;
                alu_cntrl = c_alu_sub;
                pc_src    = 2'b01;
                branch    = (opcode == c_op_beq);
                branch_ne = (opcode == c_op_bne);
                state_d   = ST_FETCH;
            end
            ST_ADDIEXEC: begin
                aluSrc_a  = 1'b1;
                aluSrc_b  = 2'b10;
                alu_cntrl = c_alu_add;
                state_d   = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                regWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // Any state change clears the count, so every mem_req state is entered at 0.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_req && !mem_ready)
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign state_o = state_q;

`ifdef MIPS_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == ST_FETCH && state_q != ST_FETCH)
            instr_cnt_d = instr_cnt_q + 1'b1;
        if (state_q != ST_FAULT)
            cycle_cnt_d = cycle_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_ctrl_ws
// Purpose  : Self-checking bench for mips_mc_ctrl_ws (MEM_TIMEOUT=4,
//            CNT_WIDTH=4). Each cycle pushes the expected state, control
//            vector and counter values; they are popped and compared on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl_ws;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_WIDTH   = 4;
`ifdef MIPS_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [5:0]           opcode = '0;
    logic [5:0]           funct = '0;
    logic                 mem_ready = 1'b0;
    logic                 mem_req, memWrite, pc_write, branch, branch_ne, iRwrite;
    logic                 regWrite, IorD, regDst, memToReg, aluSrc_a, fault;
    logic [1:0]           aluSrc_b, pc_src;
    logic [2:0]           alu_cntrl;
    logic [3:0]           state_o;
    logic [CNT_WIDTH-1:0] instr_cnt, cycle_cnt;

    mips_mc_ctrl_ws #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .memWrite(memWrite), .pc_write(pc_write), .branch(branch),
        .branch_ne(branch_ne), .iRwrite(iRwrite), .regWrite(regWrite), .IorD(IorD),
        .regDst(regDst), .memToReg(memToReg), .aluSrc_a(aluSrc_a), .aluSrc_b(aluSrc_b),
        .pc_src(pc_src), .alu_cntrl(alu_cntrl), .fault(fault), .state_o(state_o),
        .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // {mem_req, memWrite, pc_write, branch, branch_ne, iRwrite, regWrite, IorD,
    //  regDst, memToReg, aluSrc_a, aluSrc_b, pc_src, alu_cntrl, fault}
    logic [18:0] act_ctrl;
    assign act_ctrl = {mem_req, memWrite, pc_write, branch, branch_ne, iRwrite, regWrite,
                       IorD, regDst, memToReg, aluSrc_a, aluSrc_b, pc_src, alu_cntrl, fault};

    typedef struct packed {
        logic [3:0]           st;
        logic [18:0]          ctrl;
        logic [CNT_WIDTH-1:0] ic;
        logic [CNT_WIDTH-1:0] cc;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;

    logic [CNT_WIDTH-1:0] m_ic, m_cc;
    logic [3:0]           m_prev;

    // Control table for each state.
    function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic rdy);
        logic ms, mw, pw, br, bn, ir, rw, iod, rd, m2r, sa, ft;
        logic [1:0] sb_, ps;
        logic [2:0] alu;
        {ms, mw, pw, br, bn, ir, rw, iod, rd, m2r, sa, ft} = '0;
        sb_ = 2'b00; ps = 2'b00; alu = 3'b000;
        case (st)
            4'd0:  begin ms = 1; sb_ = 2'b01; alu = 3'b010; pw = rdy; ir = rdy; end
            4'd1:  begin sb_ = 2'b11; alu = 3'b010; end
            4'd2, 4'd9: begin sa = 1; sb_ = 2'b10; alu = 3'b010; end
            4'd3:  begin ms = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin ms = 1; iod = 1; mw = 1; end
            4'd6:  begin
                sa = 1;
                case (fn)
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
            end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; alu = 3'b110; ps = 2'b01; br = (op == OP_BEQ); bn = (op == OP_BNE); end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pw = 1; end
            4'd12: ft = 1;
            default: ;
        endcase
        return {ms, mw, pw, br, bn, ir, rw, iod, rd, m2r, sa, sb_, ps, alu, ft};
    endfunction

    // One clock cycle: drive, push expectation, compare on falling edge.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic [3:0] st, input string name);
        exp_t e, a;
        opcode = op; funct = fn; mem_ready = rdy;
        if (st == 4'd0 && m_prev != 4'd0) m_ic = m_ic + 1'b1;
        e.st   = st;
        e.ctrl = exp_ctrl(st, op, fn, rdy);
        e.ic   = PERF ? m_ic : '0;
        e.cc   = PERF ? m_cc : '0;
        sb.push_back(e);
        if (st != 4'd12) m_cc = m_cc + 1'b1;
        m_prev = st;
        @(negedge clk);
        total_cnt++;
        if (sb.size() == 0) begin
            fail_cnt++;
            $display("FAIL %s scoreboard: got empty queue, required one entry", name);
        end else begin
            a = sb.pop_front();
            if (state_o !== a.st || act_ctrl !== a.ctrl || instr_cnt !== a.ic || cycle_cnt !== a.cc) begin
                fail_cnt++;
                $display("FAIL %s: got st=%0d ctrl=%b ic=%0d cc=%0d, required st=%0d ctrl=%b ic=%0d cc=%0d",
                         name, state_o, act_ctrl, instr_cnt, cycle_cnt, a.st, a.ctrl, a.ic, a.cc);
            end else begin
                pass_cnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_ic = '0; m_cc = '0; m_prev = 4'd0;
    endtask

    task automatic test_reset();
        do_reset();
        step(OP_R, FN_ADD, 1'b0, 4'd0, "reset_fetch");
        // Abort an access in progress; no wait count may carry over.
        step(OP_LW, 6'd0, 1'b1, 4'd0, "rst_mid_fetch");
        step(OP_LW, 6'd0, 1'b1, 4'd1, "rst_mid_decode");
        step(OP_LW, 6'd0, 1'b1, 4'd2, "rst_mid_memadr");
        step(OP_LW, 6'd0, 1'b0, 4'd3, "rst_mid_memrd");
        step(OP_LW, 6'd0, 1'b0, 4'd3, "rst_mid_memrd");
        do_reset();
        for (int i = 0; i < 3; i++) step(OP_LW, 6'd0, 1'b0, 4'd0, "rst_fetch_wait");
        step(OP_LW, 6'd0, 1'b1, 4'd0, "rst_fetch_ready");
        step(OP_LW, 6'd0, 1'b1, 4'd1, "rst_decode");
        step(OP_LW, 6'd0, 1'b1, 4'd2, "rst_memadr");
        step(OP_LW, 6'd0, 1'b1, 4'd3, "rst_memrd");
        step(OP_LW, 6'd0, 1'b1, 4'd4, "rst_memwb");
    endtask

    task automatic test_lw();
        step(OP_LW, 6'd0, 1'b1, 4'd0, "lw_fetch");
        step(OP_LW, 6'd0, 1'b1, 4'd1, "lw_decode");
        step(OP_LW, 6'd0, 1'b1, 4'd2, "lw_memadr");
        step(OP_LW, 6'd0, 1'b1, 4'd3, "lw_memrd");
        step(OP_LW, 6'd0, 1'b1, 4'd4, "lw_memwb");
        // Wait states in MEMRD with ready arriving on the last allowed cycle.
        step(OP_LW, 6'd0, 1'b1, 4'd0, "lwws_fetch");
        step(OP_LW, 6'd0, 1'b1, 4'd1, "lwws_decode");
        step(OP_LW, 6'd0, 1'b1, 4'd2, "lwws_memadr");
        for (int i = 0; i < 3; i++) step(OP_LW, 6'd0, 1'b0, 4'd3, "lwws_memrd_wait");
        step(OP_LW, 6'd0, 1'b1, 4'd3, "lwws_memrd_ready");
        step(OP_LW, 6'd0, 1'b1, 4'd4, "lwws_memwb");
    endtask

    task automatic test_sw_wait();
        step(OP_SW, 6'd0, 1'b1, 4'd0, "sw_fetch");
        step(OP_SW, 6'd0, 1'b1, 4'd1, "sw_decode");
        step(OP_SW, 6'd0, 1'b1, 4'd2, "sw_memadr");
        for (int i = 0; i < 3; i++) step(OP_SW, 6'd0, 1'b0, 4'd5, "sw_memwr_wait");
        step(OP_SW, 6'd0, 1'b1, 4'd5, "sw_memwr_ready");
    endtask

    task automatic test_rtype();
        logic [5:0] fns [5];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 5; i++) begin
            step(OP_R, fns[i], 1'b1, 4'd0, "r_fetch");
            step(OP_R, fns[i], 1'b1, 4'd1, "r_decode");
            step(OP_R, fns[i], 1'b1, 4'd6, "r_execute");
            step(OP_R, fns[i], 1'b1, 4'd7, "r_aluwb");
        end
    endtask

    task automatic test_branch();
        step(OP_BEQ, 6'd0, 1'b1, 4'd0, "beq_fetch");
        step(OP_BEQ, 6'd0, 1'b1, 4'd1, "beq_decode");
        step(OP_BEQ, 6'd0, 1'b1, 4'd8, "beq_branch");
        step(OP_BNE, 6'd0, 1'b1, 4'd0, "bne_fetch");
        step(OP_BNE, 6'd0, 1'b1, 4'd1, "bne_decode");
        step(OP_BNE, 6'd0, 1'b1, 4'd8, "bne_branch");
    endtask

    task automatic test_addi_jump();
        step(OP_ADDI, 6'd0, 1'b1, 4'd0, "addi_fetch");
        step(OP_ADDI, 6'd0, 1'b1, 4'd1, "addi_decode");
        step(OP_ADDI, 6'd0, 1'b1, 4'd9, "addi_exec");
        step(OP_ADDI, 6'd0, 1'b1, 4'd10, "addi_wb");
        step(OP_J, 6'd0, 1'b1, 4'd0, "j_fetch");
        step(OP_J, 6'd0, 1'b1, 4'd1, "j_decode");
        step(OP_J, 6'd0, 1'b1, 4'd11, "j_jump");
        step(OP_J, 6'd0, 1'b0, 4'd0, "j_back_fetch");
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) step(OP_R, FN_ADD, 1'b0, 4'd0, "to_fetch_wait");
        for (int i = 0; i < 10; i++) step(OP_R, FN_ADD, i[0], 4'd12, "to_fault_sticky");
        do_reset();
        step(OP_R, FN_ADD, 1'b0, 4'd0, "to_after_reset");
        // Timeout inside MEMWR
        step(OP_SW, 6'd0, 1'b1, 4'd0, "to_sw_fetch");
        step(OP_SW, 6'd0, 1'b1, 4'd1, "to_sw_decode");
        step(OP_SW, 6'd0, 1'b1, 4'd2, "to_sw_memadr");
        for (int i = 0; i < 4; i++) step(OP_SW, 6'd0, 1'b0, 4'd5, "to_memwr_wait");
        step(OP_SW, 6'd0, 1'b1, 4'd12, "to_memwr_fault");
    endtask

    task automatic test_illegal();
        do_reset();
        step(OP_BAD, 6'd0, 1'b1, 4'd0, "bad_op_fetch");
        step(OP_BAD, 6'd0, 1'b1, 4'd1, "bad_op_decode");
        step(OP_R, FN_ADD, 1'b1, 4'd12, "bad_op_fault");
        do_reset();
        step(OP_R, 6'b000000, 1'b1, 4'd0, "bad_fn_fetch");
        step(OP_R, 6'b000000, 1'b1, 4'd1, "bad_fn_decode");
        step(OP_R, 6'b000000, 1'b1, 4'd12, "bad_fn_fault");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(OP_R, FN_ADD, 1'b1, 4'd0, "b2b_fetch");
            step(OP_R, FN_ADD, 1'b1, 4'd1, "b2b_decode");
            step(OP_R, FN_ADD, 1'b1, 4'd6, "b2b_execute");
            step(OP_R, FN_ADD, 1'b1, 4'd7, "b2b_aluwb");
        end
        // 17 retired -> wraps to 1; 68 active cycles -> 68 mod 16 = 4.
        total_cnt++;
        if (instr_cnt !== (PERF ? 4'd1 : 4'd0) || cycle_cnt !== (PERF ? 4'd4 : 4'd0)) begin
            fail_cnt++;
            $display("FAIL b2b_counters: got ic=%0d cc=%0d, required ic=%0d cc=%0d",
                     instr_cnt, cycle_cnt, PERF ? 1 : 0, PERF ? 4 : 0);
        end else begin
            pass_cnt++;
        end
        step(OP_R, FN_ADD, 1'b1, 4'd0, "b2b_final_fetch");
    endtask

    initial begin
        m_ic = '0; m_cc = '0; m_prev = 4'd0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_branch();
        test_addi_jump();
        test_timeout();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
